// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, functs, ALUOp and ALU control codes, class decode helper.
// Combinational helpers only; no state and no flow control.
// Consumers: instr_decode_unit, alu_control.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic rtype;
    logic addi;
    logic andi;
    logic lw;
    logic sw;
    logic j;
    logic jal;
    logic jr;
    logic beq;
    logic bne;
    logic illegal;
  } dec_t;

  // Exactly one field is set for any opcode/funct pair.
  function automatic dec_t decode_word(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: d.rtype = 1'b1;
          FN_JR:                                 d.jr    = 1'b1;
          default:                               d.illegal = 1'b1;
        endcase
      end
      OP_ADDI: d.addi = 1'b1;
      OP_ANDI: d.andi = 1'b1;
      OP_LW:   d.lw   = 1'b1;
      OP_SW:   d.sw   = 1'b1;
      OP_J:    d.j    = 1'b1;
      OP_JAL:  d.jal  = 1'b1;
      OP_BEQ:  d.beq  = 1'b1;
      OP_BNE:  d.bne  = 1'b1;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_control.sv
// ALU control: maps ALUOp plus funct to the 3-bit ALU operation code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_AND: alu_ctrl = ALU_AND;
      default: begin
        // Unknown functs (including jr) fall back to add.
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_unit.sv
// IR/MDR plus opcode decode for the multicycle core; ILLEGAL_TRAP_EN adds illegal tracking.
// Latency: IR/MDR one edge; flags, fields and alu_ctrl combinational from registered state.
// Backpressure: none; IR loads whenever IRWrite is high, MDR every edge.
module instr_decode_unit
  import mips_pkg::*;
#(
  parameter int ILLEGAL_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              mem_rdata,
  input  logic                     IRWrite,
  input  logic [1:0]               ALUOp,
  output logic                     RT,
  output logic                     addi,
  output logic                     andi,
  output logic                     lw,
  output logic                     sw,
  output logic                     j,
  output logic                     jal,
  output logic                     jr,
  output logic                     beq,
  output logic                     bne,
  output logic                     illegal,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [31:0]              imm_sext,
  output logic [31:0]              imm_sl2,
  output logic [25:0]              jtarget,
  output logic [2:0]               alu_ctrl,
  output logic [31:0]              mdr,
  output logic                     illegal_seen,
  output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
);

  logic [31:0] ir;
  logic        ir_valid;
  dec_t        dec_ir;
  dec_t        dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir       <= '0;
      ir_valid <= 1'b0;
      mdr      <= '0;
    end else begin
      mdr <= mem_rdata;
      if (IRWrite) begin
        ir       <= mem_rdata;
        ir_valid <= 1'b1;
      end
    end
  end

  // ir_valid clears asynchronously, so flags drop the moment reset asserts.
  assign dec_ir = decode_word(ir[31:26], ir[5:0]);
  assign dec    = ir_valid ? dec_ir : '0;

  assign RT      = dec.rtype;
  assign addi    = dec.addi;
  assign andi    = dec.andi;
  assign lw      = dec.lw;
  assign sw      = dec.sw;
  assign j       = dec.j;
  assign jal     = dec.jal;
  assign jr      = dec.jr;
  assign beq     = dec.beq;
  assign bne     = dec.bne;
  assign illegal = dec.illegal;

  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign imm_sl2  = {imm_sext[29:0], 2'b00};
  assign jtarget  = ir[25:0];

  alu_control u_alu_control (
    .ALUOp    (ALUOp),
    .funct    (ir[5:0]),
    .alu_ctrl (alu_ctrl)
  );

`ifdef ILLEGAL_TRAP_EN
  dec_t dec_in;
  assign dec_in = decode_word(mem_rdata[31:26], mem_rdata[5:0]);

  // Counts each loading edge, so a held IRWrite on an illegal word counts repeatedly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_seen <= 1'b0;
      illegal_cnt  <= '0;
    end else if (IRWrite && dec_in.illegal) begin
      illegal_seen <= 1'b1;
      if (illegal_cnt != {ILLEGAL_CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + ILLEGAL_CNT_W'(1);
    end
  end
`else
  assign illegal_seen = 1'b0;
  assign illegal_cnt  = '0;
`endif

endmodule

// File: tb/tb_instr_decode_unit.sv
// Directed self-checking bench for instr_decode_unit with hand-computed expectations.
module tb_instr_decode_unit;

  logic        clk;
  logic        rst;
  logic [31:0] mem_rdata;
  logic        IRWrite;
  logic [1:0]  ALUOp;
  logic        RT, addi, andi, lw, sw, j, jal, jr, beq, bne, illegal;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, imm_sl2, mdr;
  logic [25:0] jtarget;
  logic [2:0]  alu_ctrl;
  logic        illegal_seen;
  logic [7:0]  illegal_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  instr_decode_unit #(.ILLEGAL_CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rdata    (mem_rdata),
    .IRWrite      (IRWrite),
    .ALUOp        (ALUOp),
    .RT           (RT),
    .addi         (addi),
    .andi         (andi),
    .lw           (lw),
    .sw           (sw),
    .j            (j),
    .jal          (jal),
    .jr           (jr),
    .beq          (beq),
    .bne          (bne),
    .illegal      (illegal),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .imm_sext     (imm_sext),
    .imm_sl2      (imm_sl2),
    .jtarget      (jtarget),
    .alu_ctrl     (alu_ctrl),
    .mdr          (mdr),
    .illegal_seen (illegal_seen),
    .illegal_cnt  (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: RT addi andi lw sw j jal jr beq bne illegal
  localparam logic [10:0] F_NONE = 11'h000;
  localparam logic [10:0] F_RT   = 11'h400;
  localparam logic [10:0] F_ADDI = 11'h200;
  localparam logic [10:0] F_LW   = 11'h080;
  localparam logic [10:0] F_JR   = 11'h008;
  localparam logic [10:0] F_BEQ  = 11'h004;
  localparam logic [10:0] F_ILL  = 11'h001;

  function automatic logic [10:0] flags();
    return {RT, addi, andi, lw, sw, j, jal, jr, beq, bne, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    mem_rdata = w;
    IRWrite   = 1'b1;
    tick();
    IRWrite   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; mem_rdata = '0; IRWrite = 1'b0; ALUOp = 2'b00;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();

    check("rst_flags", 32'(flags()), 32'(F_NONE));
    check("rst_mdr", mdr, 32'h0);
    check("rst_aluctrl", 32'(alu_ctrl), 32'h2);
    check("rst_jtarget", 32'(jtarget), 32'h0);
    check("rst_seen", 32'(illegal_seen), 32'h0);
    check("rst_cnt", 32'(illegal_cnt), 32'h0);

    // add $t0,$t1,$t2
    load(32'h012A4020);
    ALUOp = 2'b10; #1;
    check("add_flags", 32'(flags()), 32'(F_RT));
    check("add_rs", 32'(rs), 32'd9);
    check("add_rt", 32'(rt), 32'd10);
    check("add_rd", 32'(rd), 32'd8);
    check("add_alu", 32'(alu_ctrl), 32'h2);
    ALUOp = 2'b01; #1;
    check("aluop_sub", 32'(alu_ctrl), 32'h6);
    ALUOp = 2'b11; #1;
    check("aluop_and", 32'(alu_ctrl), 32'h0);
    tick();
    check("add_hold", 32'(flags()), 32'(F_RT));

    // slt
    ALUOp = 2'b10;
    load(32'h012A402A);
    check("slt_alu", 32'(alu_ctrl), 32'h7);
    load(32'h012A4025);
    check("or_alu", 32'(alu_ctrl), 32'h1);
    load(32'h012A4022);
    check("sub_alu", 32'(alu_ctrl), 32'h6);

    // addi $t0,$t1,-4
    ALUOp = 2'b00;
    load(32'h2128FFFC);
    check("addi_flags", 32'(flags()), 32'(F_ADDI));
    check("addi_sext", imm_sext, 32'hFFFFFFFC);
    check("addi_sl2", imm_sl2, 32'hFFFFFFF0);
    check("addi_alu", 32'(alu_ctrl), 32'h2);

    // jr $ra; funct 001000 under funct decode falls back to add
    load(32'h03E00008);
    check("jr_flags", 32'(flags()), 32'(F_JR));
    check("jr_rs", 32'(rs), 32'd31);
    ALUOp = 2'b10; #1;
    check("jr_alu", 32'(alu_ctrl), 32'h2);
    ALUOp = 2'b00;

    // lw then MDR capture one cycle later
    load(32'h8D280004);
    check("lw_flags", 32'(flags()), 32'(F_LW));
    check("lw_mdr_ir_word", mdr, 32'h8D280004);
    mem_rdata = 32'hDEADBEEF;
    tick();
    check("lw_mdr", mdr, 32'hDEADBEEF);
    check("lw_imm_hold", imm_sext, 32'h4);
    check("lw_flags_hold", 32'(flags()), 32'(F_LW));

    // Held IRWrite: last sample wins
    IRWrite = 1'b1;
    mem_rdata = 32'h012A4020; tick();
    mem_rdata = 32'h11090003; tick();
    IRWrite = 1'b0;
    mem_rdata = 32'h2128FFFC; tick();
    check("held_flags", 32'(flags()), 32'(F_BEQ));
    check("held_imm", imm_sext, 32'h3);

    // Illegal opcode
    load(32'hFC000000);
    check("ill_flags", 32'(flags()), 32'(F_ILL));
`ifdef ILLEGAL_TRAP_EN
    check("ill_seen", 32'(illegal_seen), 32'h1);
    check("ill_cnt1", 32'(illegal_cnt), 32'h1);
`else
    check("ill_seen_off", 32'(illegal_seen), 32'h0);
    check("ill_cnt_off", 32'(illegal_cnt), 32'h0);
`endif
    // R-type with unsupported funct
    load(32'h00000001);
    check("ill_funct", 32'(flags()), 32'(F_ILL));
`ifdef ILLEGAL_TRAP_EN
    check("ill_cnt2", 32'(illegal_cnt), 32'h2);
    mem_rdata = 32'hFC000000;
    IRWrite = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    IRWrite = 1'b0;
    check("ill_cnt_sat", 32'(illegal_cnt), 32'hFF);
`endif
    // A legal load afterwards does not count
    load(32'h11090003);
    check("beq_flags", 32'(flags()), 32'(F_BEQ));
`ifdef ILLEGAL_TRAP_EN
    check("cnt_after_legal", 32'(illegal_cnt), 32'hFF);
    check("seen_sticky", 32'(illegal_seen), 32'h1);
`endif

    // Async reset mid-instruction
    mem_rdata = 32'h12345678;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_flags", 32'(flags()), 32'(F_NONE));
    check("arst_jtarget", 32'(jtarget), 32'h0);
    check("arst_mdr", mdr, 32'h0);
    check("arst_cnt", 32'(illegal_cnt), 32'h0);
    check("arst_seen", 32'(illegal_seen), 32'h0);
    tick();
    rst = 1'b1;
    mem_rdata = 32'h0;
    tick();
    check("post_rst_flags", 32'(flags()), 32'(F_NONE));
    check("post_rst_imm", imm_sext, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
